prover_compute_w0_tm: RTL and testbench
=======================================

Name: prover_compute_w0_tm

Overview:
- Computes w0[i] = (w2_m_w1[i]*tau + w1[i]) mod p for all ninbits elements at the end of a sumcheck round.
- Time-multiplexes a configurable number of multiply-add lanes (nlanes) across the elements. Area can therefore be traded against latency.
- Sits in the prover layer between the sumcheck engine (which holds w1 and w2_m_w1) and the next layer's input-point registers.

Parameters:
- ninbits, 3, number of w0 elements (>=1).
- nlanes, 1, number of parallel mul-add lanes (1..ninbits). Derived npasses = ceil(ninbits/nlanes).

Ports:
- clk  in  1  clock.
- rstb  in  1  asynchronous active-low reset.
- en  in  1  start request; rising-edge sensitive.
- w1  in  `F_NBITS x ninbits  per-element w1 evaluations.
- w2_m_w1  in  `F_NBITS x ninbits  per-element (w2-w1) evaluations.
- tau  in  `F_NBITS  verifier challenge.
- ready  out  1  idle/results valid.
- ready_pulse  out  1  one-cycle pulse on completion.
- w0  out  `F_NBITS x ninbits  registered results.

Behaviour:
- Reset values: ready=1, ready_pulse=0, all w0=0, FSM=IDLE, pass counter=0, internal en-delay register=1. The en-delay reset value of 1 means en held high through reset does not start a run.
- Start:
  - A start is detected on the cycle where en=1 and en was 0 the previous cycle, while in IDLE.
  - On start, tau is captured into an internal register, pass=0, and the FSM moves to LAUNCH.
  - ready falls on the next edge.
  - Starts detected outside IDLE are ignored.
- Input stability: w1 and w2_m_w1 must be held stable from start until ready rises. Changes to tau after start have no effect.
- FSM states:
  - IDLE: ready=1. Waits for a start.
  - LAUNCH (1 cycle):
    - Lane l receives element e = pass*nlanes + l.
    - Lanes with e >= ninbits receive zero operands and a discard flag.
    - All lanes get a single-cycle en pulse. Next state is WAIT.
  - WAIT:
    - Holds until every active lane reports ready. Lanes may have data-dependent latency; no fixed count is assumed.
    - In the cycle all lanes are ready, each non-discarded lane result is written to w0[e].
    - If pass == npasses-1, next state is DONE. Otherwise pass increments and the FSM returns to LAUNCH.
  - DONE (1 cycle): sets ready=1 and ready_pulse=1, then returns to IDLE. ready_pulse is 0 in all other cycles.
- Output validity:
  - w0 registers update pass by pass and are valid only when ready=1.
  - Elements not yet reached keep their previous-run values until overwritten.
- Arithmetic: all values are in [0,p). Multiply and add are reduced mod p. No out-of-range input checking is done; out-of-range inputs are undefined.
- Latency: start-to-ready = 1 + npasses*(1 + L_lane) + 1 cycles for fixed lane latency L_lane.
- Boundaries:
  - nlanes = ninbits gives a single pass.
  - If ninbits is not a multiple of nlanes, the final pass has idle lanes that produce no writes.
  - An en rising edge in the same cycle as DONE is ignored. A new run requires en to fall and rise again after ready=1.
  - rstb asserted mid-run aborts immediately to the reset values. Lane state is also reset.

Decomposition:
- Shared package/defines:
  - `F_NBITS and the modulus p, from the existing field arithmetic defines.
  - FSM state enum {IDLE, LAUNCH, WAIT, DONE}.
  - A clog2-style helper for the pass-counter width.
- One sub-module: prover_compute_w0_lane.
  - Function: one mul-add mod p, r = a*b + c.
  - Interface: en/ready handshake plus a ready_pulse output.
  - Built from the codebase's field multiplier and adder.
  - Top instantiates nlanes copies in a generate loop; operand muxing and the pass counter live in the top.

Test Plan:
- ninbits=3, nlanes=1; w1={5,0,1}, w2_m_w1={3,4,p-1}, tau=7, pulse en -> after 3 passes w0={26,28,p-6}. ready_pulse asserts exactly once; ready low for the whole run.
- ninbits=5, nlanes=2 (3 passes, last pass one idle lane); w1[i]=i, w2_m_w1[i]=1, tau=10 -> w0={10,11,12,13,14}. Exactly 3 LAUNCH cycles observed.
- Wrap-around: w2_m_w1=p-1, tau=2, w1=1 -> w0=p-1. Also w2_m_w1=0, tau=p-1, w1=9 -> w0=9.
- Change tau one cycle after start, and hold en high through completion -> results use the captured tau. No second run starts until en falls and rises again.
- Reset and abort:
  - After rstb release with en already high -> ready=1, ready_pulse never asserts, no run starts.
  - Assert rstb during WAIT -> all outputs return to reset values.
  - A subsequent clean run on nlanes=ninbits=3 produces correct results.

Source files
------------

// File: rtl/prover_compute_w0_tm_pkg.sv
// Shared field parameters, FSM encodings and helpers for the w0 compute block.
// The field is GF(p) with p = 2^61 - 1 (a Mersenne prime); every value lives in [0, p).
package prover_compute_w0_tm_pkg;

    localparam int F_NBITS = 61;

    localparam logic [F_NBITS-1:0] P_MOD = {F_NBITS{1'b1}};

    // FSM encodings for the top-level pass sequencer
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Width needed to count 0..n-1, never less than one bit so single-pass
    // configurations still get a legal register.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    // Modular addition for operands already in [0, p): one conditional subtract.
    function automatic logic [F_NBITS-1:0] mod_add(input logic [F_NBITS-1:0] x,
                                                   input logic [F_NBITS-1:0] y);
        logic [F_NBITS:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, P_MOD}) begin
            s = s - {1'b0, P_MOD};
        end
        return s[F_NBITS-1:0];
    endfunction

endpackage

// File: rtl/prover_compute_w0_lane.sv
// One multiply-add lane: r = (a*b + c) mod p.
// The product is formed MSB-first by double-and-add over the bits of b, so the
// lane needs only modular adders. en is accepted only while ready is high;
// ready drops on the accepting edge and rises together with a one-cycle
// ready_pulse once r holds the new result.
module prover_compute_w0_lane
    import prover_compute_w0_tm_pkg::*;
(
    input  logic               clk,
    input  logic               rstb,
    input  logic               en,
    input  logic [F_NBITS-1:0] a,
    input  logic [F_NBITS-1:0] b,
    input  logic [F_NBITS-1:0] c,
    output logic               ready,
    output logic               ready_pulse,
    output logic [F_NBITS-1:0] r
);

    localparam int CW = clog2_min1(F_NBITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(F_NBITS - 1);

    logic [F_NBITS-1:0] a_q;
    logic [F_NBITS-1:0] b_q;
    logic [F_NBITS-1:0] c_q;
    logic [F_NBITS-1:0] acc;
    logic [F_NBITS-1:0] acc_next;
    logic [CW-1:0]      bit_cnt;
    logic               mul_busy;
    logic               add_pend;

    // One double-and-add step: acc = 2*acc (+ a when the current top bit of b is set)
    always_comb begin
        acc_next = mod_add(acc, acc);
        if (b_q[F_NBITS-1]) begin
            acc_next = mod_add(acc_next, a_q);
        end
    end

    // Operand capture, bit-serial multiply, then a final add of c into the result
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            acc         <= '0;
            bit_cnt     <= '0;
            mul_busy    <= 1'b0;
            add_pend    <= 1'b0;
            ready       <= 1'b1;
            ready_pulse <= 1'b0;
            r           <= '0;
        end else begin
            ready_pulse <= 1'b0;
            if (en && ready) begin
                a_q      <= a;
                b_q      <= b;
                c_q      <= c;
                acc      <= '0;
                bit_cnt  <= LAST_BIT;
                mul_busy <= 1'b1;
                ready    <= 1'b0;
            end else if (mul_busy) begin
                acc <= acc_next;
                b_q <= {b_q[F_NBITS-2:0], 1'b0};
                if (bit_cnt == '0) begin
                    mul_busy <= 1'b0;
                    add_pend <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt - CW'(1);
                end
            end else if (add_pend) begin
                r           <= mod_add(acc, c_q);
                add_pend    <= 1'b0;
                ready       <= 1'b1;
                ready_pulse <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/prover_compute_w0_tm.sv
// Computes w0[i] = (w2_m_w1[i]*tau + w1[i]) mod p for all ninbits elements,
// time-multiplexing nlanes mul-add lanes over ceil(ninbits/nlanes) passes.
// Element i is always handled by lane (i % nlanes) in pass (i / nlanes), so
// both the operand mux and the write-back use constant element/lane pairs.
module prover_compute_w0_tm
    import prover_compute_w0_tm_pkg::*;
#(
    parameter int ninbits = 3,
    parameter int nlanes  = 1
)
(
    input  logic                            clk,
    input  logic                            rstb,
    input  logic                            en,
    input  logic [ninbits-1:0][F_NBITS-1:0] w1,
    input  logic [ninbits-1:0][F_NBITS-1:0] w2_m_w1,
    input  logic [F_NBITS-1:0]              tau,
    output logic                            ready,
    output logic                            ready_pulse,
    output logic [ninbits-1:0][F_NBITS-1:0] w0
);

    localparam int NPASSES = (ninbits + nlanes - 1) / nlanes;
    localparam int PW      = clog2_min1(NPASSES);
    localparam logic [PW-1:0] LAST_PASS = PW'(NPASSES - 1);

    logic [1:0]                     state;
    logic [PW-1:0]                  pass;
    logic [F_NBITS-1:0]             tau_q;
    logic                           en_d;
    logic                           lane_en;
    logic [nlanes-1:0][F_NBITS-1:0] lane_a;
    logic [nlanes-1:0][F_NBITS-1:0] lane_b;
    logic [nlanes-1:0][F_NBITS-1:0] lane_c;
    logic [nlanes-1:0][F_NBITS-1:0] lane_r;
    logic [nlanes-1:0]              lane_ready;
    logic [nlanes-1:0]              lane_pulse;
    logic [nlanes-1:0]              lane_seen;
    logic                           all_done;

    assign lane_en = (state == ST_LAUNCH);

    // A lane counts as finished only once it is ready and has pulsed since the
    // last launch, so a lane that is slow to drop ready is never taken as done.
    assign all_done = &(lane_ready & (lane_seen | lane_pulse));

    // Route this pass's elements to their lanes; lanes with no element this pass
    // get zero operands and nothing is ever written back from them.
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        lane_c = '0;
        for (int i = 0; i < ninbits; i++) begin
            if (pass == PW'(i / nlanes)) begin
                lane_a[i % nlanes] = w2_m_w1[i];
                lane_b[i % nlanes] = tau_q;
                lane_c[i % nlanes] = w1[i];
            end
        end
    end

    for (genvar g = 0; g < nlanes; g++) begin : g_lane
        prover_compute_w0_lane u_lane (
            .clk         (clk),
            .rstb        (rstb),
            .en          (lane_en),
            .a           (lane_a[g]),
            .b           (lane_b[g]),
            .c           (lane_c[g]),
            .ready       (lane_ready[g]),
            .ready_pulse (lane_pulse[g]),
            .r           (lane_r[g])
        );
    end

    // Sticky record of which lanes have completed in the current pass
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            lane_seen <= '0;
        end else if (state == ST_LAUNCH) begin
            lane_seen <= '0;
        end else begin
            lane_seen <= lane_seen | lane_pulse;
        end
    end

    // Pass sequencer: edge-detect the start, launch each pass, collect results
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= ST_IDLE;
            pass        <= '0;
            tau_q       <= '0;
            en_d        <= 1'b1;
            ready       <= 1'b1;
            ready_pulse <= 1'b0;
            w0          <= '0;
        end else begin
            en_d        <= en;
            ready_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en && !en_d) begin
                        tau_q <= tau;
                        pass  <= '0;
                        ready <= 1'b0;
                        state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (all_done) begin
                        for (int i = 0; i < ninbits; i++) begin
                            if (pass == PW'(i / nlanes)) begin
                                w0[i] <= lane_r[i % nlanes];
                            end
                        end
                        if (pass == LAST_PASS) begin
                            ready       <= 1'b1;
                            ready_pulse <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            pass  <= pass + PW'(1);
                            state <= ST_LAUNCH;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prover_compute_w0_tm.sv
// Bench for prover_compute_w0_tm: three instances (3x1, 5x2, 3x3) driven with
// directed vectors; expected w0 vectors go into per-instance queues and are
// popped by monitors whenever an instance pulses ready_pulse.
module tb_prover_compute_w0_tm;
    import prover_compute_w0_tm_pkg::*;

    typedef logic [F_NBITS-1:0] fe_t;
    typedef logic [4:0][F_NBITS-1:0] vec_t;

    logic clk;
    logic rstb;

    logic                    en_a, en_b, en_c;
    logic [2:0][F_NBITS-1:0] w1_a, w2_a, w0_a;
    logic [4:0][F_NBITS-1:0] w1_b, w2_b, w0_b;
    logic [2:0][F_NBITS-1:0] w1_c, w2_c, w0_c;
    fe_t                     tau_a, tau_b, tau_c;
    logic                    ready_a, ready_b, ready_c;
    logic                    pulse_a, pulse_b, pulse_c;

    vec_t exp_q_a[$];
    vec_t exp_q_b[$];
    vec_t exp_q_c[$];

    int checks;
    int errors;
    int pulses_a, pulses_b, pulses_c;
    int launches_b;

    prover_compute_w0_tm #(.ninbits(3), .nlanes(1)) dut_a (
        .clk(clk), .rstb(rstb), .en(en_a), .w1(w1_a), .w2_m_w1(w2_a), .tau(tau_a),
        .ready(ready_a), .ready_pulse(pulse_a), .w0(w0_a));

    prover_compute_w0_tm #(.ninbits(5), .nlanes(2)) dut_b (
        .clk(clk), .rstb(rstb), .en(en_b), .w1(w1_b), .w2_m_w1(w2_b), .tau(tau_b),
        .ready(ready_b), .ready_pulse(pulse_b), .w0(w0_b));

    prover_compute_w0_tm #(.ninbits(3), .nlanes(3)) dut_c (
        .clk(clk), .rstb(rstb), .en(en_c), .w1(w1_c), .w2_m_w1(w2_c), .tau(tau_c),
        .ready(ready_c), .ready_pulse(pulse_c), .w0(w0_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input fe_t act, input fe_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic dut_ready(input int which);
        case (which)
            0: return ready_a;
            1: return ready_b;
            default: return ready_c;
        endcase
    endfunction

    function automatic logic dut_pulse(input int which);
        case (which)
            0: return pulse_a;
            1: return pulse_b;
            default: return pulse_c;
        endcase
    endfunction

    // Monitor for instance A: each completion pops one expected w0 vector
    always @(negedge clk) begin : mon_a
        vec_t e;
        if (rstb && pulse_a) begin
            pulses_a++;
            if (exp_q_a.size() == 0) begin
                check_output("a_unexpected_pulse", fe_t'(1), fe_t'(0));
            end else begin
                e = exp_q_a.pop_front();
                for (int i = 0; i < 3; i++) check_output($sformatf("a_w0[%0d]", i), w0_a[i], e[i]);
            end
        end
    end

    // Monitor for instance B
    always @(negedge clk) begin : mon_b
        vec_t e;
        if (rstb && pulse_b) begin
            pulses_b++;
            if (exp_q_b.size() == 0) begin
                check_output("b_unexpected_pulse", fe_t'(1), fe_t'(0));
            end else begin
                e = exp_q_b.pop_front();
                for (int i = 0; i < 5; i++) check_output($sformatf("b_w0[%0d]", i), w0_b[i], e[i]);
            end
        end
        if (rstb && dut_b.state == ST_LAUNCH) launches_b++;
    end

    // Monitor for instance C
    always @(negedge clk) begin : mon_c
        vec_t e;
        if (rstb && pulse_c) begin
            pulses_c++;
            if (exp_q_c.size() == 0) begin
                check_output("c_unexpected_pulse", fe_t'(1), fe_t'(0));
            end else begin
                e = exp_q_c.pop_front();
                for (int i = 0; i < 3; i++) check_output($sformatf("c_w0[%0d]", i), w0_c[i], e[i]);
            end
        end
    end

    task automatic push_exp(input int which, input fe_t e0, input fe_t e1, input fe_t e2,
                            input fe_t e3, input fe_t e4);
        vec_t v;
        v[0] = e0; v[1] = e1; v[2] = e2; v[3] = e3; v[4] = e4;
        case (which)
            0: exp_q_a.push_back(v);
            1: exp_q_b.push_back(v);
            default: exp_q_c.push_back(v);
        endcase
    endtask

    // Raise en for one cycle on the selected instance
    task automatic apply_stimulus(input int which);
        @(negedge clk);
        case (which) 0: en_a = 1'b1; 1: en_b = 1'b1; default: en_c = 1'b1; endcase
        @(negedge clk);
        case (which) 0: en_a = 1'b0; 1: en_b = 1'b0; default: en_c = 1'b0; endcase
    endtask

    // Wait (bounded) for completion, requiring ready low for the whole run
    task automatic wait_done(input int which, input string name);
        int  high_cycles;
        bit  seen;
        high_cycles = 0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
            if (dut_pulse(which)) begin
                seen = 1'b1;
            end else begin
                if (dut_ready(which)) high_cycles++;
                @(negedge clk);
            end
        end
        check_output({name, "_completed"}, fe_t'(seen), fe_t'(1));
        check_output({name, "_ready_high_cycles"}, fe_t'(high_cycles), fe_t'(0));
        @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0;
        pulses_a = 0; pulses_b = 0; pulses_c = 0; launches_b = 0;
        rstb = 1'b0;
        en_a = 1'b1; en_b = 1'b0; en_c = 1'b0;
        w1_a = '0; w2_a = '0; tau_a = '0;
        w1_b = '0; w2_b = '0; tau_b = '0;
        w1_c = '0; w2_c = '0; tau_c = '0;

        // Reset state with en_a already high
        repeat (3) @(negedge clk);
        check_output("rst_ready_a", fe_t'(ready_a), fe_t'(1));
        check_output("rst_pulse_a", fe_t'(pulse_a), fe_t'(0));
        check_output("rst_ready_b", fe_t'(ready_b), fe_t'(1));
        for (int i = 0; i < 3; i++) check_output($sformatf("rst_w0_a[%0d]", i), w0_a[i], fe_t'(0));
        rstb = 1'b1;
        repeat (10) @(negedge clk);
        check_output("en_high_at_release_ready", fe_t'(ready_a), fe_t'(1));
        check_output("en_high_at_release_state", fe_t'(dut_a.state), fe_t'(ST_IDLE));
        check_output("en_high_at_release_pulses", fe_t'(pulses_a), fe_t'(0));
        en_a = 1'b0;

        // 3 elements, 1 lane
        w1_a[0] = 5; w1_a[1] = 0; w1_a[2] = 1;
        w2_a[0] = 3; w2_a[1] = 4; w2_a[2] = P_MOD - 1;
        tau_a = 7;
        push_exp(0, 26, 28, P_MOD - 6, 0, 0);
        apply_stimulus(0);
        wait_done(0, "a_run1");
        repeat (3) @(negedge clk);
        check_output("a_run1_pulse_count", fe_t'(pulses_a), fe_t'(1));

        // 5 elements, 2 lanes: three passes, last one has an idle lane
        for (int i = 0; i < 5; i++) begin
            w1_b[i] = fe_t'(i);
            w2_b[i] = 1;
        end
        tau_b = 10;
        launches_b = 0;
        push_exp(1, 10, 11, 12, 13, 14);
        apply_stimulus(1);
        wait_done(1, "b_run1");
        check_output("b_launch_count", fe_t'(launches_b), fe_t'(3));

        // Wrap-around with tau = 2
        w1_a[0] = 1; w1_a[1] = 9; w1_a[2] = 4;
        w2_a[0] = P_MOD - 1; w2_a[1] = 0; w2_a[2] = 3;
        tau_a = 2;
        push_exp(0, P_MOD - 1, 9, 10, 0, 0);
        apply_stimulus(0);
        wait_done(0, "a_wrap_tau2");

        // Wrap-around with tau = p-1
        w1_a[0] = 9; w1_a[1] = 0; w1_a[2] = 5;
        w2_a[0] = 0; w2_a[1] = 1; w2_a[2] = 2;
        tau_a = P_MOD - 1;
        push_exp(0, 9, P_MOD - 1, 3, 0, 0);
        apply_stimulus(0);
        wait_done(0, "a_wrap_taupm1");

        // tau changed after start, en held high through completion
        w1_c[0] = 1; w1_c[1] = 2; w1_c[2] = 3;
        w2_c[0] = 1; w2_c[1] = 1; w2_c[2] = 1;
        tau_c = 4;
        push_exp(2, 5, 6, 7, 0, 0);
        @(negedge clk);
        en_c = 1'b1;
        @(negedge clk);
        tau_c = 100;
        wait_done(2, "c_tau_change");
        repeat (10) @(negedge clk);
        check_output("c_held_en_pulses", fe_t'(pulses_c), fe_t'(1));
        check_output("c_held_en_ready", fe_t'(ready_c), fe_t'(1));
        en_c = 1'b0;
        @(negedge clk);
        push_exp(2, 101, 102, 103, 0, 0);
        en_c = 1'b1;
        @(negedge clk);
        wait_done(2, "c_rerun");
        en_c = 1'b0;

        // Abort instance A mid-run with reset
        w1_a[0] = 2; w1_a[1] = 3; w1_a[2] = 4;
        tau_a = 6;
        push_exp(0, 0, 0, 0, 0, 0);
        apply_stimulus(0);
        repeat (20) @(negedge clk);
        check_output("abort_in_wait_state", fe_t'(dut_a.state), fe_t'(ST_WAIT));
        rstb = 1'b0;
        #1;
        check_output("abort_ready", fe_t'(ready_a), fe_t'(1));
        check_output("abort_pulse", fe_t'(pulse_a), fe_t'(0));
        for (int i = 0; i < 3; i++) check_output($sformatf("abort_w0_a[%0d]", i), w0_a[i], fe_t'(0));
        for (int i = 0; i < 3; i++) check_output($sformatf("abort_w0_c[%0d]", i), w0_c[i], fe_t'(0));
        exp_q_a.delete();
        @(negedge clk);
        rstb = 1'b1;
        repeat (3) @(negedge clk);

        // Clean run after reset, 3 lanes in a single pass
        w1_c[0] = 7; w1_c[1] = 8; w1_c[2] = 9;
        w2_c[0] = 2; w2_c[1] = 3; w2_c[2] = P_MOD - 1;
        tau_c = 5;
        push_exp(2, 17, 23, 4, 0, 0);
        apply_stimulus(2);
        wait_done(2, "c_clean");

        repeat (5) @(negedge clk);
        check_output("final_pulses_a", fe_t'(pulses_a), fe_t'(3));
        check_output("final_pulses_b", fe_t'(pulses_b), fe_t'(1));
        check_output("final_pulses_c", fe_t'(pulses_c), fe_t'(3));
        check_output("final_queue_b", fe_t'(exp_q_b.size()), fe_t'(0));
        check_output("final_queue_c", fe_t'(exp_q_c.size()), fe_t'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
